pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
//  A scoreboard tracks in-flight destination registers and stalls ID on RAW hazards.
//  It flushes wrong-path stages when a branch or jump redirect resolves at the EX/MEM register.
//  It also keeps stall/flush perf counters and runs a stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_scoreboard.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects, scoreboard entry.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HANG  = 2'd3
  } ctrl_state_t;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       ld;
  } sb_entry_t;

  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  // Youngest producer wins; a WB hit needs no forward since the regfile catches it.
  function automatic fwd_sel_t fwdPick(input logic exHit, input logic memHit);
    if (exHit)       return FWD_EXMEM;
    else if (memHit) return FWD_MEMWB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Three-entry in-flight destination tracker (EX/MEM/WB) with per-stage source match vectors.
// PIPE_HAZARD_FORWARD_EN additionally exposes whether the EX entry is a load.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  sb_entry_t           insEntry,
  input  logic [4:0]          srcRs,
  input  logic [4:0]          srcRt,
  input  logic                usesRs,
  input  logic                usesRt,
  output logic [SB_DEPTH-1:0] rsMatch,
  output logic [SB_DEPTH-1:0] rtMatch
`ifdef PIPE_HAZARD_FORWARD_EN
  ,
  output logic                exIsLoad
`endif
);

  sb_entry_t [SB_DEPTH-1:0] sb;

  // A redirect kills the wrong-path instruction moving from EX into MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb[SB_WB]  <= sb[SB_MEM];
      sb[SB_MEM] <= kill ? '0 : sb[SB_EX];
      sb[SB_EX]  <= insEntry;
    end
  end

  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_match
    assign rsMatch[i] = sb[i].v && (sb[i].dst != 5'd0) && (sb[i].dst == srcRs) && usesRs;
    assign rtMatch[i] = sb[i].v && (sb[i].dst != 5'd0) && (sb[i].dst == srcRt) && usesRt;
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  assign exIsLoad = sb[SB_EX].ld;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/redirect controller with perf counters and stall watchdog.
// Define PIPE_HAZARD_FORWARD_EN to add EX forwarding selects and load-use-only stalls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wb_en,
  input  logic [4:0]       id_dst,
  input  logic             id_is_load,
  input  logic             redirect,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang_err,
  output logic [1:0]       ctrl_state
`ifdef PIPE_HAZARD_FORWARD_EN
  ,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
`endif
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  logic [SB_DEPTH-1:0] rsMatch, rtMatch;
  logic                hazard, stall, runHit;
  sb_entry_t           insEntry;
  ctrl_state_t         state;
  logic [RUN_W-1:0]    stallRun;

`ifdef PIPE_HAZARD_FORWARD_EN
  logic exIsLoad;
`endif

  pipe_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .kill     (redirect),
    .insEntry (insEntry),
    .srcRs    (id_rs),
    .srcRt    (id_rt),
    .usesRs   (id_uses_rs),
    .usesRt   (id_uses_rt),
    .rsMatch  (rsMatch),
    .rtMatch  (rtMatch)
`ifdef PIPE_HAZARD_FORWARD_EN
    ,
    .exIsLoad (exIsLoad)
`endif
  );

`ifdef PIPE_HAZARD_FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hazard = exIsLoad && (rsMatch[SB_EX] || rtMatch[SB_EX]);
`else
  assign hazard = (|rsMatch) || (|rtMatch);
`endif

  assign stall = id_valid && !redirect && hazard;

  always_comb begin
    insEntry = '0;
    if (!(stall || redirect || !id_valid || !id_wb_en)) begin
      insEntry.v   = 1'b1;
      insEntry.dst = id_dst;
      insEntry.ld  = id_is_load;
    end
  end

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (redirect) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (stall) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_bubble  = 1'b1;
    end
  end

  // This stall is the MAX_STALL-th in a row.
  assign runHit = stall && (stallRun >= RUN_W'(MAX_STALL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      stallRun <= '0;
      hang_err <= 1'b0;
    end else begin
      if (!stall)
        stallRun <= '0;
      else if (stallRun != RUN_W'(MAX_STALL))
        stallRun <= stallRun + RUN_W'(1);

      if (state == HANG || runHit) begin
        state    <= HANG;
        hang_err <= 1'b1;
      end else if (redirect) begin
        state <= FLUSH;
      end else if (stall) begin
        state <= STALL;
      end else begin
        state <= RUN;
      end
    end
  end

  assign ctrl_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  always_ff @(posedge clk) begin
    if (rst || stall || redirect || !id_valid) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      fwd_a_sel <= fwdPick(rsMatch[SB_EX], rsMatch[SB_MEM]);
      fwd_b_sel <= fwdPick(rtMatch[SB_EX], rtMatch[SB_MEM]);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with MAX_STALL=3 exercises the watchdog.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic S = !FWD;  // stalls that only occur without forwarding
  localparam int MAXH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_wb_en = 0, id_is_load = 0, redirect = 0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;

  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_bubble, hang_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0] ctrl_state, fa, fb;
  logic hPc, hIfId, hFlush, hIdB, hExB, hHang;
  logic [31:0] hScnt, hFcnt;
  logic [1:0] hState;
`ifndef PIPE_HAZARD_FORWARD_EN
  assign fa = 2'b00;
  assign fb = 2'b00;
`else
  logic [1:0] hFa, hFb;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wb_en(id_wb_en), .id_dst(id_dst),
    .id_is_load(id_is_load), .redirect(redirect), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hang_err(hang_err), .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_FORWARD_EN
    , .fwd_a_sel(fa), .fwd_b_sel(fb)
`endif
  );

  pipe_hazard_ctrl #(.MAX_STALL(MAXH)) dutH (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wb_en(id_wb_en), .id_dst(id_dst),
    .id_is_load(id_is_load), .redirect(redirect), .pc_we(hPc), .if_id_we(hIfId),
    .if_id_flush(hFlush), .id_ex_bubble(hIdB), .ex_mem_bubble(hExB),
    .stall_cnt(hScnt), .flush_cnt(hFcnt), .hang_err(hHang), .ctrl_state(hState)
`ifdef PIPE_HAZARD_FORWARD_EN
    , .fwd_a_sel(hFa), .fwd_b_sel(hFb)
`endif
  );

  typedef struct packed {
    logic pc, ifid, fl, idb, exb, hang;
    logic [1:0] st;
    logic [31:0] scnt, fcnt;
    logic [1:0] fa, fb;
  } exp_t;
  typedef struct packed { logic pc, hang; logic [1:0] st; } hexp_t;

  exp_t  q[$];
  hexp_t hq[$];
  int checks = 0, errors = 0;

  // Reference state: index 0 = main instance, 1 = watchdog instance.
  logic [31:0] mScnt = '0, mFcnt = '0;
  logic [1:0]  mSt[2] = '{RUN, RUN};
  logic        mHang[2] = '{1'b0, 1'b0};
  int          mRun[2] = '{0, 0};
  int          mMax[2] = '{16, MAXH};
  logic [1:0]  mFa = '0, mFb = '0;

  task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wb, input logic [4:0] dst,
                      input logic ld, input logic rd, input logic expStall,
                      input logic [1:0] nFa, input logic [1:0] nFb);
    exp_t e, o;
    hexp_t he, ho;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wb_en = wb; id_dst = dst; id_is_load = ld; redirect = rd;
    e.pc   = !rst && !expStall;
    e.ifid = !rst && !expStall;
    e.fl   = rst || rd;
    e.idb  = rst || rd || expStall;
    e.exb  = rst || rd;
    e.hang = mHang[0]; e.st = mSt[0];
    e.scnt = mScnt;    e.fcnt = mFcnt;
    e.fa   = mFa;      e.fb = mFb;
    q.push_back(e);
    he.pc = e.pc; he.hang = mHang[1]; he.st = mSt[1];
    hq.push_back(he);
    #2;
    o = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_bubble, hang_err, ctrl_state,
         stall_cnt, flush_cnt, fa, fb};
    ho = {hPc, hHang, hState};
    e = q.pop_front();
    he = hq.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s main: got %h want %h", tag, o, e);
    end
    checks++;
    assert (ho === he) else begin
      errors++;
      $error("FAIL %s watchdog: got %h want %h", tag, ho, he);
    end
    // advance the reference across the coming clock edge
    if (rst) begin
      mScnt = '0; mFcnt = '0; mFa = '0; mFb = '0;
      for (int k = 0; k < 2; k++) begin mSt[k] = RUN; mHang[k] = 1'b0; mRun[k] = 0; end
    end else begin
      if (expStall) mScnt = mScnt + 1;
      if (rd) mFcnt = mFcnt + 1;
      for (int k = 0; k < 2; k++) begin
        if (expStall) begin if (mRun[k] < mMax[k]) mRun[k]++; end
        else mRun[k] = 0;
        if (mSt[k] == HANG || (expStall && mRun[k] >= mMax[k])) begin
          mSt[k] = HANG; mHang[k] = 1'b1;
        end else mSt[k] = rd ? FLUSH : (expStall ? STALL : RUN);
      end
      if (expStall || rd || !v || !FWD) begin mFa = '0; mFb = '0; end
      else begin mFa = nFa; mFb = nFb; end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  initial begin
    @(negedge clk);
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // add $3 ; add $4,$3,$1
    step("t1_prod", 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00);
    step("t1_dep0", 1, 3, 1, 1, 1, 1, 4, 0, 0, S, 2'b01, 2'b00);
    step("t1_dep1", 1, 3, 1, 1, 1, 1, 4, 0, 0, S, 2'b10, 2'b00);
    step("t1_dep2", 1, 3, 1, 1, 1, 1, 4, 0, 0, S, 2'b00, 2'b00);
    step("t1_go",   1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 2'b00, 2'b00);
    idle(4);

    // redirect while ID holds a dependent of $5; the killed $6 must never appear
    step("t2_prod",  1, 1, 2, 1, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00);
    step("t2_redir", 1, 5, 5, 1, 1, 1, 6, 0, 1, 0, 2'b00, 2'b00);
    step("t2_rd6",   1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("t2_rd5",   1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    idle(3);

    // $0 writers then readers
    step("t3_w0",  1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("t3_w0b", 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("t3_r0",  1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    step("t3_r0b", 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    idle(3);

    // lw $2 ; add $5,$2,$2
    step("t4_lw",   1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 2'b00, 2'b00);
    step("t4_use0", 1, 2, 2, 1, 1, 1, 5, 0, 0, 1, 2'b00, 2'b00);
    step("t4_use1", 1, 2, 2, 1, 1, 1, 5, 0, 0, S, 2'b10, 2'b10);
    step("t4_use2", 1, 2, 2, 1, 1, 1, 5, 0, 0, S, 2'b00, 2'b00);
    step("t4_use3", 1, 2, 2, 1, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00);
    idle(3);

    // add $2 ; add $5,$2,$2
    step("t4_add",  1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 2'b00, 2'b00);
    step("t4_dep0", 1, 2, 2, 1, 1, 1, 5, 0, 0, S, 2'b01, 2'b01);
    step("t4_dep1", 1, 2, 2, 1, 1, 1, 5, 0, 0, S, 2'b10, 2'b10);
    step("t4_dep2", 1, 2, 2, 1, 1, 1, 5, 0, 0, S, 2'b00, 2'b00);
    step("t4_dep3", 1, 2, 2, 1, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00);
    idle(3);

    // reset in the middle of a load-use stall
    step("t6_lw",    1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 2'b00, 2'b00);
    step("t6_stall", 1, 7, 0, 1, 0, 1, 8, 0, 0, 1, 2'b00, 2'b00);
    rst = 1'b1;
    step("t6_rst",   1, 7, 0, 1, 0, 1, 8, 0, 0, 0, 2'b00, 2'b00);
    rst = 1'b0;
    step("t6_after", 1, 7, 0, 1, 0, 1, 8, 0, 0, 0, 2'b00, 2'b00);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
